// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides, a persistent
// flag register {N,Z,F,L,C} and an iterative shift-add multiplier.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. Only one
// op is in flight. result/flags hold steady while out_valid && !out_ready.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SH_W  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDC = 8'h07;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_MOV  = 8'h0D;
  localparam logic [7:0] OP_MUL  = 8'h0E;
  localparam logic [7:0] OP_LSH  = 8'h84;

  // Bit positions inside the flag register.
  localparam int FC = 0;
  localparam int FL = 1;
  localparam int FF = 2;
  localparam int FZ = 3;
  localparam int FN = 4;

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] mul_a, mul_b, acc, acc_nxt;
  logic [CNT_W-1:0] cnt;

  logic             accept, start_mul, mul_done;
  logic             is_sub;
  logic [WIDTH-1:0] b_neg, b_eff;
  logic [WIDTH:0]   sum;
  logic             ovf;

  logic signed [SH_W:0] amt;
  logic [SH_W:0]        mag;
  logic [WIDTH-1:0]     shifted;

  logic [WIDTH-1:0] op_res;
  logic [4:0]       op_flags;

  assign in_ready  = !reset && (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign start_mul = accept && (opcode == OP_MUL);
  assign mul_done  = (state == ST_MUL) && (cnt == CNT_W'(WIDTH - 1));

  // Shared adder: SUB adds the two's complement of b; ADDC injects stored C.
  assign is_sub = (opcode == OP_SUB);
  assign b_neg  = ~b + WIDTH'(1);
  assign b_eff  = is_sub ? b_neg : b;
  assign sum    = is_sub ? ({1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1))
                         : ({1'b0, a} + {1'b0, b} +
                            {{WIDTH{1'b0}}, (opcode == OP_ADDC) && flags[FC]});
  assign ovf    = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

  // Signed shift amount: non-negative shifts left, negative shifts right.
  assign amt     = {b[SH_W-1], b[SH_W-1:0]};
  assign mag     = amt[SH_W] ? -amt : amt;
  assign shifted = (int'(mag) >= WIDTH) ? '0 : (amt[SH_W] ? (a >> mag) : (a << mag));

  assign acc_nxt = mul_b[0] ? (acc + mul_a) : acc;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: MUL occupies the block for WIDTH cycles
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_mul) state_nxt = ST_MUL;
      ST_MUL:  if (mul_done)  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Single-cycle op decode: result and updated flag vector
  always_comb begin
    op_res   = '0;
    op_flags = flags;
    case (opcode)
      OP_AND: begin op_res = a & b; op_flags[FZ] = (op_res == '0); end
      OP_OR:  begin op_res = a | b; op_flags[FZ] = (op_res == '0); end
      OP_XOR: begin op_res = a ^ b; op_flags[FZ] = (op_res == '0); end
      OP_ADD, OP_ADDC: begin
        op_res       = sum[WIDTH-1:0];
        op_flags[FC] = sum[WIDTH];
        op_flags[FF] = ovf;
        op_flags[FZ] = (op_res == '0);
        op_flags[FN] = op_res[WIDTH-1];
      end
      OP_SUB: begin
        op_res       = sum[WIDTH-1:0];
        op_flags[FC] = (a < b);
        op_flags[FF] = ovf;
        op_flags[FZ] = (op_res == '0);
        op_flags[FN] = op_res[WIDTH-1];
      end
      OP_CMP: begin
        op_res       = a;
        op_flags[FZ] = (a == b);
        op_flags[FL] = (a < b);
        op_flags[FN] = ($signed(a) < $signed(b));
      end
      OP_MOV: op_res = b;
      OP_LSH: begin op_res = shifted; op_flags[FZ] = (op_res == '0); end
      default: op_res = '0;
    endcase
  end

  // Multiplier: one conditional add and operand shift per MUL cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_a <= '0;
      mul_b <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (start_mul) begin
      mul_a <= a;
      mul_b <= b;
      acc   <= '0;
      cnt   <= '0;
    end else if (state == ST_MUL) begin
      acc   <= acc_nxt;
      mul_a <= mul_a << 1;
      mul_b <= mul_b >> 1;
      cnt   <= cnt + CNT_W'(1);
    end
  end

  // Output register: load on completion, drop valid once consumed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result    <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
    end else if (mul_done) begin
      result    <= acc_nxt;
      out_valid <= 1'b1;
    end else if (accept && !start_mul) begin
      result    <= op_res;
      flags     <= op_flags;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=16): directed vectors, expected {result,flags}
// queued at issue and popped by an independent output monitor.
module tb_alu_seq;

  localparam int W = 16;

  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDC = 8'h07;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_MOV  = 8'h0D;
  localparam logic [7:0] OP_MUL  = 8'h0E;
  localparam logic [7:0] OP_LSH  = 8'h84;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   opcode;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [4:0]   flags;

  int checks = 0;
  int errors = 0;

  logic [W+4:0] exp_q[$];
  string        name_q[$];
  logic [W+4:0] mon_e;
  string        mon_n;

  // Clock and DUT
  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flags(flags)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every delivered result is matched against the scoreboard
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got result 0x%0h with nothing expected", result);
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        check({mon_n, "_result"}, 32'(result), 32'(mon_e[W+4:5]));
        check({mon_n, "_flags"},  32'(flags),  32'(mon_e[4:0]));
      end
    end
  end

  // Issue one request; call at posedge+1, returns at posedge+1 after accept
  task automatic send(input string name, input logic [7:0] op, input logic [W-1:0] va,
                      input logic [W-1:0] vb, input logic [W-1:0] er, input logic [4:0] ef);
    int n;
    exp_q.push_back({er, ef});
    name_q.push_back(name);
    opcode = op; a = va; b = vb; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: in_ready stayed 0 for %0d cycles, required 1", name, n);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    @(posedge clk);
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_result", 32'(result), 32'h0);
    check("reset_flags", 32'(flags), 32'h0);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    reset = 1'b0;
    #1 check("reset_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;

    // flags are {N,Z,F,L,C}
    send("add_ovf",   OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 5'b10100);
    send("add_carry", OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 5'b01001);
    send("addc_c1",   OP_ADDC, 16'h0000, 16'h0000, 16'h0001, 5'b00000);
    send("add_c_nz",  OP_ADD,  16'hFFFF, 16'h0002, 16'h0001, 5'b00001);
    send("and_keepc", OP_AND,  16'hFFFF, 16'h0000, 16'h0000, 5'b01001);
    send("addc_c2",   OP_ADDC, 16'h0000, 16'h0000, 16'h0001, 5'b00000);
    send("cmp_lt",    OP_CMP,  16'h0003, 16'hFFFF, 16'h0003, 5'b00010);
    send("cmp_eq",    OP_CMP,  16'h0005, 16'h0005, 16'h0005, 5'b01000);
    send("sub_brw",   OP_SUB,  16'h0003, 16'h0005, 16'hFFFE, 5'b10001);
    send("sub_ovf",   OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 5'b00100);
    send("or",        OP_OR,   16'h00F0, 16'h0F00, 16'h0FF0, 5'b00100);
    send("xor_zero",  OP_XOR,  16'h1234, 16'h1234, 16'h0000, 5'b01100);
    send("mov",       OP_MOV,  16'h5555, 16'hABCD, 16'hABCD, 5'b01100);
    send("lsh_l4",    OP_LSH,  16'h0001, 16'h0004, 16'h0010, 5'b00100);
    send("lsh_r15",   OP_LSH,  16'h8000, 16'hFFF1, 16'h0001, 5'b00100);
    send("lsh_r16",   OP_LSH,  16'h00FF, 16'h0010, 16'h0000, 5'b01100);
    send("illegal",   8'h55,   16'h0001, 16'h0001, 16'h0000, 5'b01100);
    wait_drain("vectors");

    // MUL: latency 17, busy cycles 1..16, operands toggled mid-op
    exp_q.push_back({16'h1230, 5'b01100});
    name_q.push_back("mul");
    opcode = OP_MUL; a = 16'h0123; b = 16'h0010; in_valid = 1'b1;
    @(negedge clk);
    check("mul_accept_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1 in_valid = 1'b0; opcode = OP_ADD; a = 16'hFFFF; b = 16'hFFFF;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      check($sformatf("mul_busy_ready_c%0d", i), 32'(in_ready), 32'h0);
      check($sformatf("mul_busy_valid_c%0d", i), 32'(out_valid), 32'h0);
      @(posedge clk);
      #1 a = ~a; b = b ^ 16'h5A5A;
    end
    @(negedge clk);
    check("mul_done_valid", 32'(out_valid), 32'h1);
    check("mul_done_ready", 32'(in_ready), 32'h1);
    wait_drain("mul");

    // Output stall: result held, next request blocked, released same cycle
    out_ready = 1'b0;
    send("stall_and", OP_AND, 16'h00F0, 16'h0FF0, 16'h00F0, 5'b00100);
    exp_q.push_back({16'hFFFF, 5'b10001});
    name_q.push_back("after_stall_sub");
    opcode = OP_SUB; a = 16'h0001; b = 16'h0002; in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check($sformatf("stall_valid_c%0d", i), 32'(out_valid), 32'h1);
      check($sformatf("stall_result_c%0d", i), 32'(result), 32'h00F0);
      check($sformatf("stall_in_ready_c%0d", i), 32'(in_ready), 32'h0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_drain("stall");

    // Reset in MUL cycle 8 aborts the op with no output
    opcode = OP_MUL; a = 16'h0003; b = 16'h0005; in_valid = 1'b1;
    @(negedge clk);
    check("abort_mul_accept", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'h0);
    check("abort_flags", 32'(flags), 32'h0);
    check("abort_result", 32'(result), 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 check("abort_in_ready", 32'(in_ready), 32'h1);
    repeat (25) @(posedge clk);
    #1;
    send("post_reset_add", OP_ADD, 16'h0002, 16'h0003, 16'h0005, 5'b00000);
    wait_drain("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
